// File: rtl/axil_rr_arbiter.sv
// Round-robin grant arbiter for a shared AXI-lite address/response path.
// Optional watchdog release is compiled in with `define AXIL_RR_ARBITER_TIMEOUT_EN.
module axil_rr_arbiter #(
  parameter int PORTS     = 4,
  parameter int BLOCK_ACK = 1,
  parameter int TIMEOUT   = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORTS-1:0]         request,
  input  logic [PORTS-1:0]         acknowledge,
  output logic [PORTS-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(PORTS)-1:0] grant_encoded,
  output logic                     timeout
);

  // state   | meaning
  // IDLE    | no grant outstanding, arbitrate on any request
  // GRANTED | grant held until release (ack, request drop, or watchdog)

  localparam int EW = $clog2(PORTS);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t           state_q, state_d;
  logic [EW-1:0]    last_q, last_d;
  logic [PORTS-1:0] grant_d;
  logic [EW-1:0]    enc_d;
  logic             valid_d;
  logic             timeout_d;
  logic             found;
  logic [EW-1:0]    winner;
  logic             release_normal;
  logic             force_rel;
  logic             arb;

  // Search starts just above the last winner, so the previous grantee is
  // considered last (i == PORTS wraps back onto it).
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    for (int i = 1; i <= PORTS; i++) begin
      idx = (int'(last_q) + i) % PORTS;
      if (!found && request[idx]) begin
        found  = 1'b1;
        winner = EW'(idx);
      end
    end
  end

  always_comb begin
    if (BLOCK_ACK != 0)
      release_normal = acknowledge[grant_encoded];
    else
      release_normal = ~request[grant_encoded];
  end

`ifdef AXIL_RR_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign force_rel = (state_q == GRANTED) && !release_normal && (cnt_q == TMAX);

  always_comb begin
    if (arb)
      cnt_d = '0;
    else if (state_q == GRANTED)
      cnt_d = cnt_q + 1'b1;
    else
      cnt_d = cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
`else
  assign force_rel = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant;
    enc_d     = grant_encoded;
    valid_d   = grant_valid;
    last_d    = last_q;
    timeout_d = 1'b0;
    arb       = 1'b0;
    case (state_q)
      IDLE: begin
        if (found)
          arb = 1'b1;
      end
      GRANTED: begin
        if (release_normal || force_rel) begin
          timeout_d = force_rel;
          if (found) begin
            arb = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            enc_d   = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (arb) begin
      state_d         = GRANTED;
      grant_d         = '0;
      grant_d[winner] = 1'b1;
      enc_d           = winner;
      valid_d         = 1'b1;
      last_d          = winner;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_q        <= EW'(PORTS - 1);
      grant         <= '0;
      grant_encoded <= '0;
      grant_valid   <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      grant         <= grant_d;
      grant_encoded <= enc_d;
      grant_valid   <= valid_d;
      timeout       <= timeout_d;
    end
  end

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Directed bench for axil_rr_arbiter: BLOCK_ACK=1 instance with TIMEOUT=8,
// plus a BLOCK_ACK=0 instance for the request-drop release mode.
module tb_axil_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, ack;
  logic [3:0] gnt;
  logic       gv;
  logic [1:0] genc;
  logic       tmo;

  logic [3:0] req_b, ack_b;
  logic [3:0] gnt_b;
  logic       gv_b;
  logic [1:0] genc_b;
  logic       tmo_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axil_rr_arbiter #(.PORTS(4), .BLOCK_ACK(1), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .request(req), .acknowledge(ack),
    .grant(gnt), .grant_valid(gv), .grant_encoded(genc), .timeout(tmo)
  );

  axil_rr_arbiter #(.PORTS(4), .BLOCK_ACK(0), .TIMEOUT(256)) dut_b (
    .clk(clk), .rst(rst), .request(req_b), .acknowledge(ack_b),
    .grant(gnt_b), .grant_valid(gv_b), .grant_encoded(genc_b), .timeout(tmo_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] e, input logic v);
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_enc"}, 32'(genc), 32'(e));
    chk({tag, "_gv"},  32'(gv), 32'(v));
  endtask

  logic [3:0] rr_seq [5];
  logic [1:0] rr_enc [5];
  logic       hold_ok;

  initial begin
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_enc = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b1; req = '0; ack = '0; req_b = '0; ack_b = '0;
    #2;
    chk_grant("reset", 4'b0000, 2'd0, 1'b0);
    chk("reset_tmo", 32'(tmo), 32'd0);
    step();
    rst = 1'b0;

    // round-robin with everyone requesting, ack one cycle after each grant
    req = 4'b1111;
    step();
    chk_grant("rr0", rr_seq[0], rr_enc[0], 1'b1);
    for (int k = 1; k < 5; k++) begin
      ack = rr_seq[k-1];
      step();
      chk_grant($sformatf("rr%0d", k), rr_seq[k], rr_enc[k], 1'b1);
    end
    ack = '0;

    // ack filtering
    ack = 4'b0001;
    step();
    chk_grant("flt_pre", 4'b0010, 2'd1, 1'b1);
    ack = 4'b0101;
    step();
    chk_grant("flt_other", 4'b0010, 2'd1, 1'b1);
    ack = 4'b0010; req = 4'b0000;
    step();
    chk_grant("flt_idle", 4'b0000, 2'd0, 1'b0);
    ack = '0;

    // wrap and skip from last=2
    req = 4'b0100;
    step();
    chk_grant("wrap_setup", 4'b0100, 2'd2, 1'b1);
    ack = 4'b0100; req = 4'b0011;
    step();
    chk_grant("wrap", 4'b0001, 2'd0, 1'b1);
    ack = 4'b0001;
    step();
    chk_grant("skip", 4'b0010, 2'd1, 1'b1);
    ack = 4'b0010; req = 4'b0100;
    step();
    chk_grant("rst_setup", 4'b0100, 2'd2, 1'b1);
    ack = '0;

    // asynchronous reset mid-grant
    rst = 1'b1;
    #1;
    chk_grant("rst_async", 4'b0000, 2'd0, 1'b0);
    chk("rst_async_tmo", 32'(tmo), 32'd0);
    rst = 1'b0; req = 4'b1111;
    step();
    chk_grant("rst_restart", 4'b0001, 2'd0, 1'b1);

    // watchdog / hold
    rst = 1'b1; #1; rst = 1'b0;
    req = 4'b0011;
    step();
    chk_grant("hold0", 4'b0001, 2'd0, 1'b1);
`ifdef AXIL_RR_ARBITER_TIMEOUT_EN
    hold_ok = 1'b1;
    for (int i = 1; i < 8; i++) begin
      step();
      if (gnt !== 4'b0001 || tmo !== 1'b0) hold_ok = 1'b0;
    end
    chk("to_hold", 32'(hold_ok), 32'd1);
    step();
    chk_grant("to_next", 4'b0010, 2'd1, 1'b1);
    chk("to_pulse", 32'(tmo), 32'd1);
    step();
    chk("to_pulse_end", 32'(tmo), 32'd0);
    chk_grant("to_after", 4'b0010, 2'd1, 1'b1);
`else
    hold_ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (gnt !== 4'b0001 || tmo !== 1'b0) hold_ok = 1'b0;
    end
    chk("hold_1000", 32'(hold_ok), 32'd1);
    chk_grant("hold_end", 4'b0001, 2'd0, 1'b1);
`endif
    req = '0;

    // BLOCK_ACK=0: release on request drop
    rst = 1'b1; #1; rst = 1'b0;
    req_b = 4'b0001;
    step();
    chk("b_g0", 32'(gnt_b), 32'b0001);
    req_b = 4'b1001; ack_b = 4'b0001;
    step();
    chk("b_hold", 32'(gnt_b), 32'b0001);
    req_b = 4'b1000; ack_b = '0;
    step();
    chk("b_g3", 32'(gnt_b), 32'b1000);
    chk("b_enc3", 32'(genc_b), 32'd3);
    chk("b_tmo", 32'(tmo_b), 32'd0);
    req_b = '0;
    step();
    chk("b_idle", 32'(gv_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
